tone_generator: RTL and testbench
=================================

Name: tone_generator

Overview:
- Consumes the 26-bit half-period count from the note decoder plus a strobe from the UART receiver, and produces a square-wave audio output for the board's mono audio amplifier.
- Holds each note for a fixed sustain time after the most recent key byte, then falls silent.
- Tracks the play/idle state and drives the amplifier enable.
- Sits directly downstream of the note decoder and drives the top-level audio pins.

Parameters:
- PERIOD_W, 26, width of note_period (matches the decoder output).
- SUSTAIN_CYCLES, 25000000, clock cycles a note sounds after its last note_valid strobe (250 ms at 100 MHz); must be >= 1.

Ports:
- clk  input  1  system clock (100 MHz).
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- note_period  input  PERIOD_W  half-period in clk cycles; values 0 and 1 mean silence/invalid.
- note_valid  input  1  one-cycle strobe: note_period is valid and is a new key press.
- audio_out  output  1  square wave to the amplifier PWM input.
- amp_en  output  1  amplifier shutdown-release; high while playing.
- playing  output  1  status; high in the PLAY state.

Behaviour:
- Reset: with rst_n low at a clk edge, go to IDLE and clear all registers.
  - Reset values: audio_out=0, amp_en=0, playing=0, phase counter=0, sustain timer=0, stored period=0.
  - Reset overrides note_valid in the same cycle, including mid-note.
- Internal state:
  - Two-state FSM: IDLE, PLAY.
  - period_q: stored half-period, PERIOD_W bits.
  - half_cnt: phase counter, PERIOD_W bits.
  - sus_cnt: sustain timer, width clog2(SUSTAIN_CYCLES+1).
  - tone: level register.
- All outputs are registered. playing=amp_en=(state==PLAY). audio_out=tone when in PLAY, otherwise 0.
- IDLE, note_valid=1 and note_period>=2:
  - Next state PLAY; period_q<=note_period; half_cnt<=0; tone<=1; sus_cnt<=SUSTAIN_CYCLES-1.
  - audio_out goes high on the same edge that samples the strobe (1-cycle latency to the output).
- IDLE, note_valid=1 and note_period<2: stay in IDLE; no register changes.
- PLAY, tone generation:
  - Each cycle, if half_cnt==period_q-1, then half_cnt<=0 and tone toggles; otherwise half_cnt increments.
  - Result: half period = period_q cycles, full period = 2*period_q cycles, duty 50%.
- PLAY, sustain: each cycle without a strobe, if sus_cnt==0 go to IDLE (tone<=0, half_cnt<=0); otherwise sus_cnt decrements.
- PLAY, note_valid=1 and note_period>=2 (retrigger), which takes priority over expiry in the same cycle:
  - sus_cnt<=SUSTAIN_CYCLES-1.
  - Same period as period_q: phase is untouched; half_cnt and tone continue as above.
  - Different period: period_q<=note_period, half_cnt<=0, tone keeps its level; the next toggle comes after note_period cycles.
- PLAY, note_valid=1 and note_period<2: immediate stop; go to IDLE with tone<=0 and half_cnt<=0 on that edge.
- Wrap-around: half_cnt never exceeds period_q-1. Because a period change clears half_cnt, a counter above the new limit cannot occur.
- SUSTAIN_CYCLES=1: the note lasts exactly 1 cycle after the strobe edge, then returns to IDLE.
- note_valid is ignored unless it is high at a clk edge. A strobe held high for N cycles counts as N retriggers.

Optional Feature:
- Macro: TONE_VOLUME_EN.
- Defined:
  - Extra input port volume [3:0] and a free-running 4-bit counter pwm_cnt, reset to 0.
  - audio_out = tone & (pwm_cnt < volume), registered.
  - volume=0 gives a constant 0; volume=15 gives 15/16 duty within each high half.
  - playing and amp_en are unaffected by volume.
- Not defined: no volume port; audio_out is the plain square wave described above.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles while driving note_valid=1, note_period=4 -> audio_out=0, playing=0, amp_en=0 throughout and on the first cycle after release.
- Basic tone (SUSTAIN_CYCLES=100): strobe with period 4 ->
  - audio_out high on the strobe edge and toggles every 4 cycles (pattern 1111 0000 ...).
  - playing drops exactly 100 cycles after the strobe edge.
  - audio_out=0 afterwards.
- Retrigger, same period (SUSTAIN_CYCLES=100): strobe period 5, then again with period 5 at cycle 60 -> no phase discontinuity; playing stays high until cycle 160.
- Period change: playing period 4, strobe period 10 mid-high-phase -> audio_out stays high for 10 more cycles, then toggles every 10 cycles.
- Silence codes: strobe note_period=1 while playing -> audio_out=0 and playing=0 on the next edge. Strobe note_period=0 in IDLE -> no change.
- Simultaneous events: strobe period 6 in the exact cycle sus_cnt==0 -> remains in PLAY, timer reloaded. Separately, rst_n=0 mid-note -> all outputs 0 after that edge.

Source files
------------

// File: rtl/tone_generator_if.sv
// Note-to-amplifier link: decoder-side note strobe in, audio and status out.
// TONE_VOLUME_EN adds the 4-bit volume control to the bundle.
interface tone_generator_if #(
    parameter int PERIOD_W = 26
);
    logic [PERIOD_W-1:0] note_period;
    logic                note_valid;
    logic                audio_out;
    logic                amp_en;
    logic                playing;
`ifdef TONE_VOLUME_EN
    logic [3:0]          volume;

    modport master (
        output note_period, note_valid, volume,
        input  audio_out, amp_en, playing
    );

    modport slave (
        input  note_period, note_valid, volume,
        output audio_out, amp_en, playing
    );
`else
    modport master (
        output note_period, note_valid,
        input  audio_out, amp_en, playing
    );

    modport slave (
        input  note_period, note_valid,
        output audio_out, amp_en, playing
    );
`endif
endinterface

// File: rtl/tone_generator.sv
// Square-wave tone generator with a retriggerable sustain timer and amplifier enable.
// Optional TONE_VOLUME_EN gates each high half-period with a 4-bit PWM volume.
module tone_generator #(
    parameter int PERIOD_W       = 26,
    parameter int SUSTAIN_CYCLES = 25000000
) (
    input  logic           clk,
    input  logic           rst_n,
    tone_generator_if.slave bus
);
    localparam int                  SUS_W      = $clog2(SUSTAIN_CYCLES + 1);
    localparam logic [SUS_W-1:0]    SUS_RELOAD = SUS_W'(SUSTAIN_CYCLES - 1);
    localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(2);
    localparam logic [PERIOD_W-1:0] ONE        = PERIOD_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] half_q, half_d;
    logic [SUS_W-1:0]    sus_q, sus_d;
    logic                tone_q, tone_d;
    logic                audio_q, audio_d;
    logic                key_ok, key_silent, at_wrap;
`ifdef TONE_VOLUME_EN
    logic [3:0]          pwm_q, pwm_d;
`endif

    assign key_ok     = bus.note_valid && (bus.note_period >= MIN_PERIOD);
    assign key_silent = bus.note_valid && (bus.note_period < MIN_PERIOD);
    assign at_wrap    = (half_q == period_q - ONE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            period_q <= '0;
            half_q   <= '0;
            sus_q    <= '0;
            tone_q   <= 1'b0;
            audio_q  <= 1'b0;
`ifdef TONE_VOLUME_EN
            pwm_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            half_q   <= half_d;
            sus_q    <= sus_d;
            tone_q   <= tone_d;
            audio_q  <= audio_d;
`ifdef TONE_VOLUME_EN
            pwm_q    <= pwm_d;
`endif
        end
    end

    // NOTE: every variable gets a hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        half_d   = half_q;
        sus_d    = sus_q;
        tone_d   = tone_q;

        unique case (state_q)
            IDLE: begin
                if (key_ok) begin
                    state_d  = PLAY;
                    period_d = bus.note_period;
                    half_d   = '0;
                    tone_d   = 1'b1;
                    sus_d    = SUS_RELOAD;
                end
            end
            PLAY: begin
                if (at_wrap) begin
                    half_d = '0;
                    tone_d = ~tone_q;
                end else begin
                    half_d = half_q + ONE;
                end

                // A fresh key beats sustain expiry; a silence code stops at once.
                if (key_silent) begin
                    state_d = IDLE;
                    tone_d  = 1'b0;
                    half_d  = '0;
                end else if (key_ok) begin
                    sus_d = SUS_RELOAD;
                    if (bus.note_period != period_q) begin
                        period_d = bus.note_period;
                        half_d   = '0;
                        tone_d   = tone_q;
                    end
                end else if (sus_q == '0) begin
                    state_d = IDLE;
                    tone_d  = 1'b0;
                    half_d  = '0;
                end else begin
                    sus_d = sus_q - SUS_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        audio_d = (state_d == PLAY) && tone_d;
`ifdef TONE_VOLUME_EN
        pwm_d   = pwm_q + 4'd1;
        audio_d = audio_d && (pwm_q < bus.volume);
`endif
    end

    assign bus.audio_out = audio_q;
    assign bus.playing   = (state_q == PLAY);
    assign bus.amp_en    = (state_q == PLAY);

endmodule

// File: tb/tb_tone_generator.sv
// Bench for tone_generator: a time-based note model checks two instances
// (sustain 100 and sustain 1) every cycle, plus directed literal expectations.
module tb_tone_generator;
    localparam int PW    = 26;
    localparam int SUS_A = 100;
    localparam int SUS_B = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          nv;
    logic [PW-1:0] np;
    int            errors = 0;
    int            checks = 0;
    bit            chk_en = 1'b0;
    logic [15:0]   pat;

    always #5 clk = ~clk;

    tone_generator_if #(.PERIOD_W(PW)) bus_a ();
    tone_generator_if #(.PERIOD_W(PW)) bus_b ();

    assign bus_a.note_valid  = nv;
    assign bus_a.note_period = np;
    assign bus_b.note_valid  = nv;
    assign bus_b.note_period = np;

    tone_generator #(.PERIOD_W(PW), .SUSTAIN_CYCLES(SUS_A)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    tone_generator #(.PERIOD_W(PW), .SUSTAIN_CYCLES(SUS_B)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    // A note is described by when it was last keyed, when its phase was last
    // anchored and at which level; outputs follow from elapsed time.
    typedef struct packed {
        int edge_n;
        bit on;
        int last;
        int ref_e;
        bit ref_lvl;
        int per;
        int sus;
    } model_t;

    model_t ma, mb;

    function automatic bit m_playing(model_t m, int e);
        return m.on && ((e - m.last) < m.sus);
    endfunction

    function automatic bit m_level(model_t m, int e);
        return m.ref_lvl ^ ((((e - m.ref_e) / m.per) % 2) == 1);
    endfunction

    function automatic model_t m_step(model_t m, bit rn, bit v, int p);
        model_t n;
        int     e;
        bit     was;
        n        = m;
        e        = m.edge_n + 1;
        n.edge_n = e;
        was      = m_playing(m, e - 1);
        if (!rn) begin
            n.on = 1'b0;
        end else if (v && p >= 2) begin
            if (!was) begin
                n.on      = 1'b1;
                n.last    = e;
                n.ref_e   = e;
                n.ref_lvl = 1'b1;
                n.per     = p;
            end else begin
                n.last = e;
                if (p != m.per) begin
                    n.ref_lvl = m_level(m, e - 1);
                    n.ref_e   = e;
                    n.per     = p;
                end
            end
        end else if (v) begin
            n.on = 1'b0;
        end else if (!was) begin
            n.on = 1'b0;
        end
        return n;
    endfunction

    initial begin
        ma = '{edge_n: 0, on: 1'b0, last: 0, ref_e: 0, ref_lvl: 1'b0, per: 1, sus: SUS_A};
        mb = '{edge_n: 0, on: 1'b0, last: 0, ref_e: 0, ref_lvl: 1'b0, per: 1, sus: SUS_B};
    end

    always @(posedge clk) begin
        ma <= m_step(ma, rst_n, nv, int'(np));
        mb <= m_step(mb, rst_n, nv, int'(np));
    end

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_play_a",  bus_a.playing,   m_playing(ma, ma.edge_n));
            check("model_amp_a",   bus_a.amp_en,    m_playing(ma, ma.edge_n));
            check("model_audio_a", bus_a.audio_out, m_playing(ma, ma.edge_n) && m_level(ma, ma.edge_n));
            check("model_play_b",  bus_b.playing,   m_playing(mb, mb.edge_n));
            check("model_amp_b",   bus_b.amp_en,    m_playing(mb, mb.edge_n));
            check("model_audio_b", bus_b.audio_out, m_playing(mb, mb.edge_n) && m_level(mb, mb.edge_n));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int p);
        nv = 1'b1;
        np = PW'(p);
        step();
        nv = 1'b0;
    endtask

    task automatic lit(input string name, input logic exp_audio, input logic exp_play);
        check({name, "_audio"}, bus_a.audio_out, exp_audio);
        check({name, "_play"},  bus_a.playing,   exp_play);
        check({name, "_amp"},   bus_a.amp_en,    exp_play);
    endtask

    initial begin
        rst_n = 1'b0;
        nv    = 1'b1;
        np    = PW'(4);
        pat   = 16'b1111000011110000;

        // Reset holds everything low even with a valid key present.
        repeat (3) begin
            step();
            chk_en = 1'b1;
            lit("reset", 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        nv    = 1'b0;
        step();
        lit("reset_release", 1'b0, 1'b0);

        // Basic tone, period 4, sustain 100 (instance B: sustain 1).
        strobe(4);
        lit("basic_e0", 1'b1, 1'b1);
        check("sus1_e0_play", bus_b.playing, 1'b1);
        for (int i = 1; i < 16; i++) begin
            step();
            if (i == 1) check("sus1_e1_play", bus_b.playing, 1'b0);
            check("basic_pattern", bus_a.audio_out, pat[15-i]);
        end
        for (int i = 16; i < 100; i++) step();
        check("basic_e99_play", bus_a.playing, 1'b1);
        step();
        lit("basic_e100", 1'b0, 1'b0);

        // Same-period retrigger at cycle 60 keeps phase and extends to 160.
        repeat (3) step();
        strobe(5);
        repeat (59) step();
        strobe(5);
        lit("retrig_e60", 1'b1, 1'b1);
        repeat (4) step();
        check("retrig_e64_audio", bus_a.audio_out, 1'b1);
        step();
        check("retrig_e65_audio", bus_a.audio_out, 1'b0);
        repeat (94) step();
        check("retrig_e159_play", bus_a.playing, 1'b1);
        step();
        lit("retrig_e160", 1'b0, 1'b0);

        // Period change mid-high: high for 10 cycles, then 10-cycle halves.
        step();
        strobe(4);
        step();
        strobe(10);
        lit("chg_e2", 1'b1, 1'b1);
        repeat (9) step();
        check("chg_e11_audio", bus_a.audio_out, 1'b1);
        step();
        check("chg_e12_audio", bus_a.audio_out, 1'b0);
        repeat (9) step();
        check("chg_e21_audio", bus_a.audio_out, 1'b0);
        step();
        check("chg_e22_audio", bus_a.audio_out, 1'b1);

        // Silence codes: 1 stops a playing note, 0 in idle does nothing.
        repeat (3) step();
        strobe(1);
        lit("silence_stop", 1'b0, 1'b0);
        strobe(0);
        lit("silence_idle", 1'b0, 1'b0);
        repeat (2) step();
        lit("silence_idle_hold", 1'b0, 1'b0);

        // Retrigger in the exact expiry cycle keeps playing and reloads.
        strobe(4);
        repeat (99) step();
        strobe(6);
        check("expiry_retrig_e100_play", bus_a.playing, 1'b1);
        repeat (99) step();
        check("expiry_retrig_e199_play", bus_a.playing, 1'b1);
        step();
        lit("expiry_retrig_e200", 1'b0, 1'b0);

        // Reset mid-note overrides a simultaneous key.
        strobe(4);
        repeat (2) step();
        rst_n = 1'b0;
        nv    = 1'b1;
        np    = PW'(4);
        step();
        lit("midnote_reset", 1'b0, 1'b0);
        check("midnote_reset_b_play", bus_b.playing, 1'b0);
        rst_n = 1'b1;
        nv    = 1'b0;
        step();
        lit("midnote_reset_release", 1'b0, 1'b0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
